// File: rtl/mem_brush.sv
// rtl/mem_brush.sv - SDRAM burst sequencer between the ADC/filter FIFOs, addr_fetch and the SDRAM command port
//
// Arbitrates between write bursts (ADC FIFO to SDRAM) and read bursts (SDRAM to filter FIFO).
// Issues one burst command at a time. Pulses wr_addr_up/rd_addr_up only after the burst has completed.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   wr_fifo_cnt       words waiting in the ADC write FIFO
//   rd_fifo_space     free words in the filter read FIFO
//   wr_addr, rd_addr  current burst addresses owned by addr_fetch
//   read_en           addr_fetch has data available to read back
//   wr_addr_up        1-cycle pulse: advance wr_addr by one burst
//   rd_addr_up        1-cycle pulse: advance rd_addr by one burst
//   frist_block       high until FIRST_N write bursts have completed
//   sd_cmd_*          burst command to the SDRAM controller (req/ack handshake, done pulse)
//   busy              sequencer not idle
//   ovf_err           sticky: write FIFO reached FULL_LVL
module mem_brush #(
    parameter int AW       = 25,
    parameter int CW       = 10,
    parameter int BURST    = 64,
    parameter int HI_WM    = 512,
    parameter int FULL_LVL = 1000,
    parameter int FIRST_N  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] wr_fifo_cnt,
    input  logic [CW-1:0] rd_fifo_space,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rd_addr,
    input  logic          read_en,
    output logic          wr_addr_up,
    output logic          rd_addr_up,
    output logic          frist_block,
    output logic          sd_cmd_req,
    output logic          sd_cmd_wr,
    output logic [AW-1:0] sd_cmd_addr,
    output logic [7:0]    sd_cmd_len,
    input  logic          sd_cmd_ack,
    input  logic          sd_cmd_done,
    output logic          busy,
    output logic          ovf_err
);

    localparam int CNT_W = $clog2(FIRST_N + 1);

    localparam logic [CW-1:0]    BURST_C = CW'(BURST);
    localparam logic [CW-1:0]    HI_WM_C = CW'(HI_WM);
    localparam logic [CW-1:0]    FULL_C  = CW'(FULL_LVL);
    localparam logic [CNT_W-1:0] FIRST_C = CNT_W'(FIRST_N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        UPD     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [AW-1:0]       cmd_addr_q, cmd_addr_d;
    logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic                frist_q, frist_d;
    // 1 = the last completed burst was a write
    logic                last_wr_q, last_wr_d;
    logic                ovf_q, ovf_d;

    logic                wr_ok;
    logic                rd_ok;

    assign wr_ok = (wr_fifo_cnt >= BURST_C);
    assign rd_ok = read_en & ~frist_q & (rd_fifo_space >= BURST_C);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            burst_cnt_q <= '0;
            frist_q     <= 1'b1;
            last_wr_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            burst_cnt_q <= burst_cnt_d;
            frist_q     <= frist_d;
            last_wr_q   <= last_wr_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        burst_cnt_d = burst_cnt_q;
        frist_d     = frist_q;
        last_wr_d   = last_wr_q;
        ovf_d       = ovf_q | (wr_fifo_cnt >= FULL_C);

        unique case (state_q)
            IDLE: begin
                // A high write-FIFO level overrides fairness. Otherwise alternate when both sides are ready.
                if (wr_ok && (wr_fifo_cnt >= HI_WM_C)) begin
                    state_d = WR_REQ;
                end else if (wr_ok && rd_ok) begin
                    state_d = last_wr_q ? RD_REQ : WR_REQ;
                end else if (wr_ok) begin
                    state_d = WR_REQ;
                end else if (rd_ok) begin
                    state_d = RD_REQ;
                end
                // The address is captured only here, so addr_fetch updates during a burst are never seen.
                if (state_d == WR_REQ) begin
                    cmd_wr_d   = 1'b1;
                    cmd_addr_d = wr_addr;
                end else if (state_d == RD_REQ) begin
                    cmd_wr_d   = 1'b0;
                    cmd_addr_d = rd_addr;
                end
            end
            WR_REQ: begin
                if (sd_cmd_ack) begin
                    state_d = WR_WAIT;
                end
            end
            RD_REQ: begin
                if (sd_cmd_ack) begin
                    state_d = RD_WAIT;
                end
            end
            WR_WAIT, RD_WAIT: begin
                if (sd_cmd_done) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                state_d   = IDLE;
                last_wr_d = cmd_wr_q;
                if (cmd_wr_q) begin
                    if (burst_cnt_q != FIRST_C) begin
                        burst_cnt_d = burst_cnt_q + CNT_ONE;
                    end
                    if (burst_cnt_q == FIRST_C - CNT_ONE) begin
                        frist_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        sd_cmd_req  = (state_q == WR_REQ) || (state_q == RD_REQ);
        sd_cmd_wr   = cmd_wr_q;
        sd_cmd_addr = cmd_addr_q;
        sd_cmd_len  = 8'(BURST - 1);
        wr_addr_up  = (state_q == UPD) &&  cmd_wr_q;
        rd_addr_up  = (state_q == UPD) && !cmd_wr_q;
        busy        = (state_q != IDLE);
        frist_block = frist_q;
        ovf_err     = ovf_q;
    end

endmodule

// File: tb/tb_mem_brush.sv
// tb/tb_mem_brush.sv - directed self-checking bench for mem_brush
module tb_mem_brush;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  wr_fifo_cnt;
    logic [9:0]  rd_fifo_space;
    logic [24:0] wr_addr;
    logic [24:0] rd_addr;
    logic        read_en;
    logic        wr_addr_up;
    logic        rd_addr_up;
    logic        frist_block;
    logic        sd_cmd_req;
    logic        sd_cmd_wr;
    logic [24:0] sd_cmd_addr;
    logic [7:0]  sd_cmd_len;
    logic        sd_cmd_ack;
    logic        sd_cmd_done;
    logic        busy;
    logic        ovf_err;

    int checks = 0;
    int failures = 0;
    logic frist_at_upd;

    always #5 clk = ~clk;

    mem_brush dut (
        .clk           (clk),
        .reset         (rst_n),
        .wr_fifo_cnt   (wr_fifo_cnt),
        .rd_fifo_space (rd_fifo_space),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .read_en       (read_en),
        .wr_addr_up    (wr_addr_up),
        .rd_addr_up    (rd_addr_up),
        .frist_block   (frist_block),
        .sd_cmd_req    (sd_cmd_req),
        .sd_cmd_wr     (sd_cmd_wr),
        .sd_cmd_addr   (sd_cmd_addr),
        .sd_cmd_len    (sd_cmd_len),
        .sd_cmd_ack    (sd_cmd_ack),
        .sd_cmd_done   (sd_cmd_done),
        .busy          (busy),
        .ovf_err       (ovf_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full burst, acting as the SDRAM controller and as addr_fetch.
    task automatic run_burst(input logic exp_wr, input int ack_delay, input int done_delay);
        logic [24:0] exp_addr;
        int n;
        int bad;
        n = 0;
        while (!sd_cmd_req && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (sd_cmd_req !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: sd_cmd_req=%b required 1", sd_cmd_req);
            return;
        end
        exp_addr = exp_wr ? wr_addr : rd_addr;
        checks++;
        if (sd_cmd_wr !== exp_wr) begin
            failures++;
            $display("FAIL cmd_wr: got %b required %b", sd_cmd_wr, exp_wr);
        end
        checks++;
        if (sd_cmd_addr !== exp_addr) begin
            failures++;
            $display("FAIL cmd_addr: got %h required %h", sd_cmd_addr, exp_addr);
        end
        checks++;
        if (sd_cmd_len !== 8'd63) begin
            failures++;
            $display("FAIL cmd_len: got %0d required 63", sd_cmd_len);
        end
        bad = 0;
        for (int i = 0; i < ack_delay; i++) begin
            if (i == ack_delay / 2) begin
                wr_addr = wr_addr ^ 25'h0aaaaa;
                rd_addr = rd_addr ^ 25'h0aaaaa;
            end
            step();
            if (sd_cmd_req !== 1'b1 || sd_cmd_wr !== exp_wr || sd_cmd_addr !== exp_addr) bad++;
        end
        if (ack_delay > 0) begin
            wr_addr = wr_addr ^ 25'h0aaaaa;
            rd_addr = rd_addr ^ 25'h0aaaaa;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL ack_hold_stable: %0d unstable cycles, required 0", bad);
            end
        end
        sd_cmd_ack = 1'b1;
        step();
        sd_cmd_ack = 1'b0;
        checks++;
        if (sd_cmd_req !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_state: req=%b busy=%b required req=0 busy=1", sd_cmd_req, busy);
        end
        bad = 0;
        for (int i = 1; i < done_delay; i++) begin
            step();
            if (wr_addr_up !== 1'b0 || rd_addr_up !== 1'b0 || sd_cmd_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL early_update: %0d bad cycles before done, required 0", bad);
        end
        sd_cmd_done = 1'b1;
        step();
        sd_cmd_done = 1'b0;
        checks++;
        if ({wr_addr_up, rd_addr_up} !== (exp_wr ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL addr_up: got wr=%b rd=%b required wr=%b rd=%b",
                     wr_addr_up, rd_addr_up, exp_wr, ~exp_wr);
        end
        frist_at_upd = frist_block;
        if (wr_addr_up) wr_addr = wr_addr + 25'd64;
        if (rd_addr_up) rd_addr = rd_addr + 25'd64;
        step();
        checks++;
        if ({wr_addr_up, rd_addr_up} !== 2'b00) begin
            failures++;
            $display("FAIL pulse_width: wr=%b rd=%b required 0 0", wr_addr_up, rd_addr_up);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({wr_addr_up, rd_addr_up, frist_block, sd_cmd_req, sd_cmd_wr, busy, ovf_err} !== 7'b0010000
            || sd_cmd_addr !== 25'd0 || sd_cmd_len !== 8'd63) begin
            failures++;
            $display("FAIL reset_state: up=%b%b frist=%b req=%b wr=%b busy=%b ovf=%b addr=%h len=%0d required frist=1 len=63 rest 0",
                     wr_addr_up, rd_addr_up, frist_block, sd_cmd_req, sd_cmd_wr, busy, ovf_err, sd_cmd_addr, sd_cmd_len);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        sd_cmd_done = 1'b1;
        step();
        sd_cmd_done = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || wr_addr_up !== 1'b0 || rd_addr_up !== 1'b0) begin
            failures++;
            $display("FAIL stray_done: busy=%b up=%b%b required 0 00", busy, wr_addr_up, rd_addr_up);
        end
    endtask

    task automatic test_first_write();
        wr_fifo_cnt = 10'd64;
        run_burst(1'b1, 0, 10);
        checks++;
        if (frist_block !== 1'b1) begin
            failures++;
            $display("FAIL frist_after_1: got %b required 1", frist_block);
        end
    endtask

    task automatic test_first_block();
        read_en = 1'b1;
        rd_fifo_space = 10'd1023;
        run_burst(1'b1, 0, 3);
        run_burst(1'b1, 0, 3);
        checks++;
        if (frist_block !== 1'b1) begin
            failures++;
            $display("FAIL frist_after_3: got %b required 1", frist_block);
        end
        run_burst(1'b1, 0, 3);
        checks++;
        if (frist_at_upd !== 1'b1 || frist_block !== 1'b0) begin
            failures++;
            $display("FAIL frist_fall: at_upd=%b after=%b required 1 then 0", frist_at_upd, frist_block);
        end
    endtask

    task automatic test_alternate();
        wr_fifo_cnt = 10'd100;
        run_burst(1'b0, 0, 2);
        run_burst(1'b1, 0, 2);
        run_burst(1'b0, 0, 2);
        run_burst(1'b1, 0, 2);
    endtask

    task automatic test_hi_wm();
        wr_fifo_cnt = 10'd600;
        run_burst(1'b1, 0, 2);
        run_burst(1'b1, 0, 2);
        run_burst(1'b1, 0, 2);
    endtask

    task automatic test_ack_hold();
        run_burst(1'b1, 50, 4);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (!sd_cmd_req && n < 20) begin
            step();
            n++;
        end
        sd_cmd_ack = 1'b1;
        step();
        sd_cmd_ack = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || sd_cmd_wr !== 1'b1 || frist_block !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_wait: busy=%b wr=%b frist=%b required 1 1 0", busy, sd_cmd_wr, frist_block);
        end
        #2;
        rst_n = 1'b0;
        wr_fifo_cnt = 10'd0;
        #1;
        checks++;
        if (sd_cmd_req !== 1'b0 || busy !== 1'b0 || frist_block !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: req=%b busy=%b frist=%b required 0 0 1", sd_cmd_req, busy, frist_block);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sd_cmd_done = 1'b1;
        step();
        sd_cmd_done = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (wr_addr_up !== 1'b0 || rd_addr_up !== 1'b0 || busy !== 1'b0) n++;
            step();
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL abandoned_burst: %0d cycles with up pulse or busy, required 0", n);
        end
    endtask

    task automatic test_ovf();
        checks++;
        if (ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_before: got %b required 0", ovf_err);
        end
        wr_fifo_cnt = 10'd1000;
        step();
        wr_fifo_cnt = 10'd10;
        checks++;
        if (ovf_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %b required 1", ovf_err);
        end
        step();
        step();
        step();
        checks++;
        if (ovf_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b required 1", ovf_err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_fifo_cnt = 10'd0;
        rd_fifo_space = 10'd0;
        wr_addr = 25'd0;
        rd_addr = 25'h100000;
        read_en = 1'b0;
        sd_cmd_ack = 1'b0;
        sd_cmd_done = 1'b0;
        test_reset();
        test_first_write();
        test_first_block();
        test_alternate();
        test_hi_wm();
        test_ack_hold();
        test_reset_mid();
        test_ovf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
